// File: rtl/keypad_entry.sv
// 4x4 hex keypad front end: column scan, row synchronizer, scan-level debounce,
// one key code per press, and a four-digit shift-in entry register.
//
// state       | meaning
// ST_IDLE     | no key held, waiting for a single-key scan
// ST_DEBOUNCE | candidate key seen, counting identical scans
// ST_PRESSED  | key accepted, counting empty scans before re-arming
module keypad_entry #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  row_i,
  output logic [3:0]  col_o,
  input  logic        clr_i,
  output logic [3:0]  key_code_o,
  output logic        key_valid_o,
  output logic [15:0] entry_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_TARGET = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_PRESSED} state_t;

  logic [3:0]    row_meta_q, row_sync_q;
  logic [CW-1:0] scan_cnt_q;
  logic [1:0]    col_idx_q;
  logic [3:0]    col_q;
  logic [15:0]   image_q, image_d;
  logic          scan_tc, scan_done;

  logic [4:0]    snap_hits;
  logic [3:0]    snap_code;
  logic          snap_key;

  state_t        state_q;
  logic [3:0]    cand_q;
  logic [DW-1:0] db_cnt_q, db_cnt_inc;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic [15:0]   entry_q;

  // Image bit {col,row} maps to the printed legend on the keypad.
  function automatic logic [3:0] code_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    code_lut = 4'h1;
      4'd1:    code_lut = 4'h4;
      4'd2:    code_lut = 4'h7;
      4'd3:    code_lut = 4'h0;
      4'd4:    code_lut = 4'h2;
      4'd5:    code_lut = 4'h5;
      4'd6:    code_lut = 4'h8;
      4'd7:    code_lut = 4'hF;
      4'd8:    code_lut = 4'h3;
      4'd9:    code_lut = 4'h6;
      4'd10:   code_lut = 4'h9;
      4'd11:   code_lut = 4'hE;
      4'd12:   code_lut = 4'hA;
      4'd13:   code_lut = 4'hB;
      4'd14:   code_lut = 4'hC;
      default: code_lut = 4'hD;
    endcase
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_i;
      row_sync_q <= row_meta_q;
    end
  end

  assign scan_tc   = (scan_cnt_q == SCAN_LAST);
  assign scan_done = scan_tc && (col_idx_q == 2'd3);

  // Rows are active-low; the image stores 1 for a pressed key.
  always_comb begin
    image_d = image_q;
    if (scan_tc) image_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scan_cnt_q <= '0;
      col_idx_q  <= 2'd0;
      col_q      <= 4'b1110;
      image_q    <= 16'h0000;
    end else if (scan_tc) begin
      scan_cnt_q <= '0;
      col_idx_q  <= col_idx_q + 2'd1;
      col_q      <= ~(4'b0001 << (col_idx_q + 2'd1));
      image_q    <= image_d;
    end else begin
      scan_cnt_q <= scan_cnt_q + CW'(1);
    end
  end

  // The snapshot includes the column sampled on this same edge.
  always_comb begin
    snap_hits = 5'd0;
    snap_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (image_d[i]) begin
        snap_hits = snap_hits + 5'd1;
        snap_code = code_lut(4'(i));
      end
    end
  end

  assign snap_key   = (snap_hits == 5'd1);
  assign db_cnt_inc = db_cnt_q + DW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cand_q      <= 4'h0;
      db_cnt_q    <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      entry_q     <= 16'h0000;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done) begin
        case (state_q)
          ST_IDLE: begin
            if (snap_key) begin
              cand_q <= snap_code;
              if (DB_TARGET == DW'(1)) begin
                key_code_q  <= snap_code;
                key_valid_q <= 1'b1;
                entry_q     <= {entry_q[11:0], snap_code};
                db_cnt_q    <= '0;
                state_q     <= ST_PRESSED;
              end else begin
                db_cnt_q <= DW'(1);
                state_q  <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (!snap_key) begin
              state_q <= ST_IDLE;
            end else if (snap_code == cand_q) begin
              if (db_cnt_inc == DB_TARGET) begin
                key_code_q  <= snap_code;
                key_valid_q <= 1'b1;
                entry_q     <= {entry_q[11:0], snap_code};
                db_cnt_q    <= '0;
                state_q     <= ST_PRESSED;
              end else begin
                db_cnt_q <= db_cnt_inc;
              end
            end else begin
              cand_q   <= snap_code;
              db_cnt_q <= DW'(1);
            end
          end
          ST_PRESSED: begin
            if (snap_key) begin
              db_cnt_q <= '0;
            end else if (db_cnt_inc == DB_TARGET) begin
              db_cnt_q <= '0;
              state_q  <= ST_IDLE;
            end else begin
              db_cnt_q <= db_cnt_inc;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
      // Clear wins over a coincident shift; the key report still goes out.
      if (clr_i) entry_q <= 16'h0000;
    end
  end

  assign col_o       = col_q;
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign entry_o     = entry_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: a keypad model drives rows from the
// column drive; expected key reports are queued and checked on each pulse.
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [3:0]  row, col, key_code;
  logic        key_valid;
  logic [15:0] entry;
  logic [15:0] held;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] entry;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;
  int   pulses_before;

  logic [3:0]  col_seq [4];
  int          seq_r [5];
  int          seq_c [5];
  logic [3:0]  seq_code [5];
  logic [15:0] seq_entry [5];

  always #5 clk = ~clk;

  // Key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      if ((held[r*4 +: 4] & ~col) != 4'h0) row[r] = 1'b0;
  end

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .row_i      (row),
    .col_o      (col),
    .clr_i      (clr),
    .key_code_o (key_code),
    .key_valid_o(key_valid),
    .entry_o    (entry)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_key(input logic [3:0] code, input logic [15:0] ent);
    exp_t e;
    e.code  = code;
    e.entry = ent;
    sb.push_back(e);
  endtask

  task automatic press(input int r, input int c);
    held[r*4 + c] = 1'b1;
  endtask

  task automatic scans(input int n);
    repeat (16 * n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  // Returns on the first negedge after Col wraps back to column 0.
  task automatic wait_scan_start();
    logic [3:0] prev;
    bit found;
    found = 0;
    prev  = col;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (prev == 4'b0111 && col == 4'b1110) found = 1;
      prev = col;
    end
    check("scan_start_timeout", found, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && key_valid === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual code=%h entry=%h required=no pulse",
                 key_code, entry);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_code", key_code, mon_e.code);
        check("pulse_entry", entry, mon_e.entry);
      end
    end
  end

  initial begin
    col_seq   = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    seq_r     = '{0, 0, 0, 0, 1};
    seq_c     = '{0, 1, 2, 3, 1};
    seq_code  = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5};
    seq_entry = '{16'h0061, 16'h0612, 16'h6123, 16'h123A, 16'h23A5};

    rst  = 1'b1;
    clr  = 1'b0;
    held = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_col", col, 4'b1110);
    check("reset_code", key_code, 4'h0);
    check("reset_valid", key_valid, 1'b0);
    check("reset_entry", entry, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      check("col_step", col, col_seq[i % 4]);
    end
    repeat (200) @(negedge clk);
    check("idle_no_pulse", pulses, 0);

    // Long hold gives a single report.
    expect_key(4'h6, 16'h0006);
    press(1, 2);
    scans(12);
    held = 16'h0000;
    scans(4);
    drain("hold6_drain");
    check("hold6_pulses", pulses, 1);

    for (int k = 0; k < 5; k++) begin
      expect_key(seq_code[k], seq_entry[k]);
      press(seq_r[k], seq_c[k]);
      scans(3);
      held = 16'h0000;
      scans(3);
    end
    drain("seq_drain");
    check("seq_entry", entry, 16'h23A5);

    press(2, 2);
    repeat (16) @(negedge clk);
    held = 16'h0000;
    scans(3);
    check("bounce9_entry", entry, 16'h23A5);

    press(2, 2);
    press(2, 3);
    scans(6);
    held = 16'h0000;
    scans(3);
    check("multi_entry", entry, 16'h23A5);

    // A one-scan gap while pressed must not re-arm; a two-scan gap does.
    expect_key(4'hB, 16'h3A5B);
    press(1, 3);
    scans(4);
    held = 16'h0000;
    repeat (16) @(negedge clk);
    press(1, 3);
    scans(4);
    held = 16'h0000;
    scans(2);
    drain("gap1_drain");
    expect_key(4'hB, 16'hA5BB);
    press(1, 3);
    scans(4);
    held = 16'h0000;
    scans(4);
    drain("gap2_drain");

    pulses_before = pulses;
    wait_scan_start();
    press(2, 1);
    repeat (20) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_reset_col", col, 4'b1110);
    check("async_reset_code", key_code, 4'h0);
    check("async_reset_entry", entry, 16'h0000);
    held = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scans(4);
    check("reset_no_pulse", pulses, pulses_before);

    expect_key(4'h1, 16'h0001);
    press(0, 0);
    scans(3);
    held = 16'h0000;
    scans(3);
    clr = 1'b1;
    expect_key(4'h7, 16'h0000);
    press(2, 0);
    scans(3);
    held = 16'h0000;
    scans(3);
    clr = 1'b0;
    drain("clr_drain");
    check("clr_entry", entry, 16'h0000);
    check("clr_code", key_code, 4'h7);

    expect_key(4'hD, 16'h000D);
    press(3, 3);
    scans(3);
    held = 16'h0000;
    scans(3);
    expect_key(4'h0, 16'h00D0);
    press(3, 0);
    scans(3);
    held = 16'h0000;
    scans(3);
    expect_key(4'hF, 16'h0D0F);
    press(3, 1);
    scans(3);
    held = 16'h0000;
    scans(3);
    expect_key(4'hE, 16'hD0FE);
    press(3, 2);
    scans(3);
    held = 16'h0000;
    scans(3);
    drain("row3_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Matrix-keypad input front end: scans a 4x4 hex keypad, debounces, and delivers one registered key code per physical press. It also shifts digits into a 16-bit entry register that the datapath consumes. It is the input-side counterpart of the seven-segment display path: the display drives digits out to the board, and this block brings digits in from the board. It runs on the board clock, not the divided datapath clock.

## Interface
- SCAN_DIV, 100000: Clk cycles each column is driven before its rows are sampled; must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; must be >= 1.
- Clk  input  1  board clock; the only clock.
- Reset  input  1  asynchronous, active-high.
- Row  input  4  keypad rows, active-low, pulled up, asynchronous to Clk.
- Col  output  4  keypad column drive, active-low one-hot.
- Clr  input  1  synchronous clear of Entry.
- KeyCode  output  4  hex value of the last accepted key.
- KeyValid  output  1  one-cycle pulse per accepted press.
- Entry  output  16  last four accepted digits; the newest digit is in [3:0].

## Operation
- Row passes through a 2-flop synchronizer before any use.
- Scan counter runs 0..SCAN_DIV-1. At the terminal count:
  - the synchronized Row is captured into a 16-bit scan image for the current column;
  - the column index advances 0→1→2→3→0;
  - Col = ~(1 << index).
- A full scan completes when column 3 is sampled. Snapshot of the image:
  - exactly one pressed key gives KEY(code);
  - zero keys or more than one key gives NONE.
- Key map, (row, col):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- Debounce FSM, evaluated once per completed scan:
  - IDLE: KEY(k) → candidate=k, count=1, go DEBOUNCE. If count reaches DEBOUNCE_SCANS (the DEBOUNCE_SCANS=1 case), accept immediately.
  - DEBOUNCE: snapshot == candidate → count+1; count reaching DEBOUNCE_SCANS means accept, go PRESSED. Different KEY(j) → candidate=j, count=1. NONE → IDLE.
  - PRESSED: NONE → count+1, and count reaching DEBOUNCE_SCANS goes to IDLE. Any KEY → count=0.
- Accept:
  - KeyCode <= candidate;
  - KeyValid pulses;
  - Entry <= {Entry[11:0], candidate}.
- No auto-repeat. A held key yields exactly one pulse.
- Clr takes priority over the shift. When Clr coincides with an accept, Entry = 0, while KeyCode and KeyValid still report the key.

## Timing
- Reset values (all asynchronous, immediate): Col=4'b1110, KeyCode=0, KeyValid=0, Entry=0, FSM=IDLE, scan counter=0, column index=0, synchronizer=4'b1111, image = no keys.
- Reset mid-scan or mid-debounce discards all progress; no pulse is emitted.
- KeyValid is high exactly one Clk cycle: the cycle after the edge that samples column 3 of the accepting scan.
- KeyCode and Entry change on that same edge. KeyCode holds until the next accept.
- Press-to-pulse latency: between (DEBOUNCE_SCANS-1)·4·SCAN_DIV and (DEBOUNCE_SCANS+1)·4·SCAN_DIV cycles, plus 2 cycles for the synchronizer.
- Clr acts on the next Clk edge.
- Col changes only on terminal-count edges, which leaves SCAN_DIV-2 cycles of settling before the next sample.

## Test plan
Bench uses SCAN_DIV=4 and DEBOUNCE_SCANS=2, so one scan is 16 cycles. The keypad model pulls Row[r] low while Col[c] is low and key (r,c) is held.
- Reset, no keys:
  - outputs hold their reset values;
  - Col steps 1110→1101→1011→0111→1110 every 4 cycles;
  - KeyValid never asserts in 200 cycles.
- Hold key (1,2) "6" for 12 scans → exactly one KeyValid pulse, KeyCode=4'h6, Entry=16'h0006.
- Press and release 1, 2, 3, A, each held and released for 3 scans → Entry=16'h123A. Then press 5 → Entry=16'h23A5.
- Bounce handling:
  - "9" present for 1 scan, then absent → no pulse, Entry unchanged;
  - "9" and "C" held together → no pulse.
- During PRESSED, release for 1 scan, then press again → no second pulse. Release for 2 scans, then press → second pulse.
- Reset asynchronous behaviour:
  - assert Reset mid-DEBOUNCE → Col=1110 before the next clock edge, and no pulse;
  - Clr coincident with an accept of "7" → KeyCode=4'h7, KeyValid pulses, Entry=16'h0000.
